// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver with valid/ready output register.
// Optional macro PARITY_EN adds an even-parity bit per frame.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   serial_in       serial data bit, taken when shift_en=1
//   shift_en        qualifies serial_in on this edge
//   sync            frame start: drops partial frame, restarts count
//   parallel_out    last completed word (registered)
//   out_valid       parallel_out holds an unconsumed word
//   out_ready       consumer accepts when out_valid & out_ready
//   overrun         sticky: a completed word was dropped
//   clr_overrun     sync clear of overrun (and parity_err)
//   parity_err      sticky parity error (0 unless PARITY_EN)
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             sync,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             parity_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] PARITY  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             done;
    logic             accept;

`ifdef PARITY_EN
    logic bad;
    logic perr_q;
`endif

    // A sync on the same edge as a new bit starts from an empty
    // register so no stale bits survive into the new frame.
    always_comb begin
        base = sync ? '0 : shift_reg;
        if (MSB_FIRST)
            shifted = {base[WIDTH-2:0], serial_in};
        else
            shifted = {serial_in, base[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state;
        cnt_d   = bit_cnt;
        sreg_d  = shift_reg;
        done    = 1'b0;
        word    = shifted;
`ifdef PARITY_EN
        bad     = 1'b0;
`endif
        if (sync && !shift_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
        end else if (shift_en) begin
            if (sync) begin
                sreg_d  = shifted;
                cnt_d   = CW'(1);
                state_d = COLLECT;
`ifdef PARITY_EN
            end else if (state == PARITY) begin
                // parity edge: data already assembled in shift_reg
                done    = 1'b1;
                word    = shift_reg;
                bad     = ^{shift_reg, serial_in};
                state_d = IDLE;
                cnt_d   = '0;
`endif
            end else if (bit_cnt == LAST) begin
                sreg_d  = shifted;
                cnt_d   = '0;
`ifdef PARITY_EN
                state_d = PARITY;
`else
                state_d = IDLE;
                done    = 1'b1;
`endif
            end else begin
                sreg_d  = shifted;
                cnt_d   = bit_cnt + 1'b1;
                state_d = COLLECT;
            end
        end
    end

    // A finished word loads when the register is empty or is being
    // drained on this same edge; otherwise it is lost.
    assign accept = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_d;
            bit_cnt   <= cnt_d;
            shift_reg <= sreg_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
        end else if (done && accept) begin
            parallel_out <= word;
            out_valid    <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (clr_overrun)
            overrun <= 1'b0;
        else if (done && !accept)
            overrun <= 1'b1;
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perr_q <= 1'b0;
        else if (clr_overrun)
            perr_q <= 1'b0;
        else if (done && bad)
            perr_q <= 1'b1;
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized bench for sipo_deserializer against a queue-based model.
// Directed cases pin the model with hand-computed words.
module tb_sipo_deserializer;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         serial_in = 1'b0;
    logic         shift_en = 1'b0;
    logic         sync = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_overrun = 1'b0;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         overrun;
    logic         parity_err;

    int total = 0;
    int bad = 0;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .sync         (sync),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Reference model: collect bits in a queue, emit a word once the
    // queue holds a full frame; first bit received is the word MSB.
    bit         q[$];
    logic [W-1:0] m_po = '0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_perr = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] w;
        bit par;
        bit fin;
        if (!rst_n) begin
            q.delete();
            m_po = '0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_perr = 1'b0;
        end else begin
            fin = 1'b0;
            w = '0;
            par = 1'b0;
            if (sync) q.delete();
            if (shift_en) q.push_back(serial_in);
            if (q.size() == FL) begin
                fin = 1'b1;
                for (int i = 0; i < W; i++) w[W-1-i] = q[i];
                for (int i = 0; i < FL; i++) par = par ^ q[i];
                q.delete();
            end
            if (fin) begin
`ifdef PARITY_EN
                if (par) m_perr = 1'b1;
`endif
                if (!m_valid || out_ready) begin
                    m_po = w;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (clr_overrun) begin
                m_ovr = 1'b0;
                m_perr = 1'b0;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        total++;
        if (parallel_out !== m_po) begin
            bad++;
            $display("FAIL data t=%0t got=%b want=%b", $time, parallel_out, m_po);
        end
        total++;
        if (out_valid !== m_valid) begin
            bad++;
            $display("FAIL valid t=%0t got=%b want=%b", $time, out_valid, m_valid);
        end
        total++;
        if (overrun !== m_ovr) begin
            bad++;
            $display("FAIL overrun t=%0t got=%b want=%b", $time, overrun, m_ovr);
        end
        total++;
        if (parity_err !== m_perr) begin
            bad++;
            $display("FAIL perr t=%0t got=%b want=%b", $time, parity_err, m_perr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; applies inputs for the next posedge and
    // returns at the following negedge.
    task automatic cyc(input bit se, input bit si, input bit sy,
                       input bit rdy, input bit clr);
        shift_en = se;
        serial_in = si;
        sync = sy;
        out_ready = rdy;
        clr_overrun = clr;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit sy_first,
                             input bit rdy_last, input bit par_flip);
        for (int i = 0; i < W; i++) begin
`ifdef PARITY_EN
            cyc(1'b1, w[W-1-i], sy_first && i == 0, 1'b0, 1'b0);
`else
            cyc(1'b1, w[W-1-i], sy_first && i == 0,
                (i == W - 1) ? rdy_last : 1'b0, 1'b0);
`endif
        end
`ifdef PARITY_EN
        cyc(1'b1, (^w) ^ par_flip, 1'b0, rdy_last, 1'b0);
`else
        if (par_flip) chk("flip_unused", 0, 0);
`endif
    endtask

    task automatic drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset asserted mid-clock, outputs must drop at once
        #3 rst_n = 1'b0;
        #1;
        chk("rst_po", int'(parallel_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // basic word, hold, then accept
        send_word(4'b1101, 1'b0, 1'b0, 1'b0);
        chk("t2_po", int'(parallel_out), 13);
        chk("t2_valid", int'(out_valid), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_hold", int'(parallel_out), 13);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_acc", int'(out_valid), 0);

        // overrun
        send_word(4'b1101, 1'b0, 1'b0, 1'b0);
        send_word(4'b0110, 1'b0, 1'b0, 1'b0);
        chk("t3_po", int'(parallel_out), 13);
        chk("t3_ovr", int'(overrun), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr", int'(overrun), 0);
        drain();

        // completion and acceptance on the same edge
        send_word(4'b1101, 1'b0, 1'b0, 1'b0);
        send_word(4'b0011, 1'b0, 1'b1, 1'b0);
        chk("t4_valid", int'(out_valid), 1);
        chk("t4_po", int'(parallel_out), 3);
        chk("t4_ovr", int'(overrun), 0);
        drain();

        // resync mid-frame
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b1010, 1'b1, 1'b0, 1'b0);
        chk("t5_sync", int'(parallel_out), 10);
        chk("t5_valid", int'(out_valid), 1);
        drain();

        // reset pulse mid-frame
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_en = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(4'b0110, 1'b0, 1'b0, 1'b0);
        chk("t5_rst", int'(parallel_out), 6);
        chk("t5_rst_v", int'(out_valid), 1);
        drain();

`ifdef PARITY_EN
        send_word(4'b1101, 1'b0, 1'b0, 1'b0);
        chk("t6_po", int'(parallel_out), 13);
        chk("t6_ok", int'(parity_err), 0);
        drain();
        send_word(4'b1101, 1'b0, 1'b0, 1'b1);
        chk("t6_po2", int'(parallel_out), 13);
        chk("t6_err", int'(parity_err), 1);
        drain();
        chk("t6_clr", int'(parity_err), 0);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r;
            r = ($urandom_range(0, 499) == 0);
            shift_en = ($urandom_range(0, 9) < 7);
            serial_in = $urandom_range(0, 1) == 1;
            sync = ($urandom_range(0, 19) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            clr_overrun = ($urandom_range(0, 19) == 0);
            if (r) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        // long back-to-back stream with consumer always ready
        for (int n = 0; n < 40; n++)
            cyc(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b1, 1'b0);
        chk("b2b_ovr", int'(overrun), int'(m_ovr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
